// File: rtl/instr_feeder.sv
// instr_feeder: buffers host instruction words in a FIFO and issues them to the processor one at a time (run/done handshake).
// Define INSTR_FEEDER_COUNT_EN to add the 16-bit 'issued' counter port.
module instr_feeder #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          in_valid,
  input  logic [15:0]   in_data,
  output logic          in_ready,
  input  logic          flush,
  input  logic          done,
  output logic [15:0]   iin,
  output logic          run,
  output logic          busy,
  output logic [AW:0]   level
`ifdef INSTR_FEEDER_COUNT_EN
  ,
  output logic [15:0]   issued
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [AW:0] full_level = (AW+1)'(DEPTH);

  state_t        state;
  state_t        state_next;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;

  // in_ready depends only on occupancy, so a full FIFO refuses a push even when a pop happens in the same cycle
  assign in_ready = (level != full_level);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (state == IDLE) && (level != '0) && !flush;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (pop)  state_next = WAIT;
        WAIT:    if (done) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == WAIT);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wptr] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      iin   <= '0;
      run   <= 1'b0;
    end else begin
      run <= pop;
      if (pop) begin
        iin <= mem[rptr];
      end
      // flush discards the queue but leaves iin holding the last issued word
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        case ({push, pop})
          2'b10:   level <= level + (AW+1)'(1);
          2'b01:   level <= level - (AW+1)'(1);
          default: level <= level;
        endcase
      end
    end
  end

`ifdef INSTR_FEEDER_COUNT_EN
  // counts issues since reset; survives flush
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      issued <= '0;
    end else if (pop) begin
      issued <= issued + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: queue-based reference model plus issue-order scoreboard for instr_feeder,
// with directed checks for sequencing, full, push/pop overlap, flush and asynchronous reset.
module tb_instr_feeder;

  localparam int DEPTH = 8;
  localparam int AW = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_data = '0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          done = 1'b0;
  logic [15:0]   iin;
  logic          run;
  logic          busy;
  logic [AW:0]   level;
`ifdef INSTR_FEEDER_COUNT_EN
  logic [15:0]   issued;
`endif

  int checkCount = 0;
  int passCount = 0;
  int runCount = 0;
  bit lastAccepted = 1'b0;

  logic [15:0] fifoQ [$];
  logic [15:0] issueQ [$];
  logic [15:0] pendQ [$];
  logic        mState = 1'b0;
  int          mLevel = 0;
  logic        mRun = 1'b0;
  logic [15:0] mIin = '0;
  logic [15:0] mIssued = '0;
  logic        mPush;
  logic        mPop;

  instr_feeder #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .flush    (flush),
    .done     (done),
    .iin      (iin),
    .run      (run),
    .busy     (busy),
    .level    (level)
`ifdef INSTR_FEEDER_COUNT_EN
    ,
    .issued   (issued)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; issues are queued for the scoreboard when they happen
  assign mPop  = !mState && (mLevel > 0) && !flush;
  assign mPush = in_valid && (mLevel < DEPTH) && !flush;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mState  <= 1'b0;
      mLevel  <= 0;
      mRun    <= 1'b0;
      mIin    <= '0;
      mIssued <= '0;
      fifoQ.delete();
      issueQ.delete();
    end else begin
      mRun <= mPop;
      if (flush) begin
        mState <= 1'b0;
        mLevel <= 0;
        fifoQ.delete();
      end else begin
        if (mPop) begin
          mIin    <= fifoQ[0];
          mIssued <= mIssued + 16'd1;
          mState  <= 1'b1;
          issueQ.push_back(fifoQ[0]);
          fifoQ.delete(0);
        end else if (mState && done) begin
          mState <= 1'b0;
        end
        if (mPush) fifoQ.push_back(in_data);
        mLevel <= mLevel + int'(mPush) - int'(mPop);
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      checkOutput("run", 32'(run), 32'(mRun));
      checkOutput("busy", 32'(busy), 32'(mState));
      checkOutput("level", 32'(level), 32'(mLevel));
      checkOutput("inReady", 32'(in_ready), 32'(mLevel < DEPTH));
      checkOutput("iinHold", 32'(iin), 32'(mIin));
`ifdef INSTR_FEEDER_COUNT_EN
      checkOutput("issued", 32'(issued), 32'(mIssued));
`endif
      if (run) begin
        if (issueQ.size() > 0) begin
          checkOutput("issueOrder", 32'(iin), 32'(issueQ[0]));
          issueQ.delete(0);
        end else begin
          checkOutput("unexpectedRun", 32'(run), 32'd0);
        end
        runCount++;
      end else if (mRun && issueQ.size() > 0) begin
        issueQ.delete(0);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic f, input logic dn);
    in_valid = v;
    in_data  = d;
    flush    = f;
    done     = dn;
    lastAccepted = v && in_ready && !f;
    @(negedge clock);
  endtask

  task automatic stepCycle(input logic dn);
    if (pendQ.size() > 0) begin
      applyStimulus(1'b1, pendQ[0], 1'b0, dn);
      if (lastAccepted) pendQ.delete(0);
    end else begin
      applyStimulus(1'b0, 16'h0000, 1'b0, dn);
    end
  endtask

  task automatic waitRun(input int limit);
    int n = 0;
    while (!run && n < limit) begin
      stepCycle(1'b0);
      n++;
    end
    if (!run) checkOutput("runTimeout", 32'(run), 32'd1);
  endtask

  task automatic drain();
    repeat (4 * DEPTH + 8) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("drainLevel", 32'(level), 32'd0);
    checkOutput("drainBusy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] seqWords [4];
    int baseRuns;
    int acceptedCount;
    seqWords = '{16'hA40A, 16'hA805, 16'h0120, 16'h8000};

    repeat (2) @(negedge clock);
    checkOutput("rstIin", 32'(iin), 32'h0);
    checkOutput("rstRun", 32'(run), 32'h0);
    checkOutput("rstBusy", 32'(busy), 32'h0);
    checkOutput("rstLevel", 32'(level), 32'h0);
    checkOutput("rstInReady", 32'(in_ready), 32'h1);
`ifdef INSTR_FEEDER_COUNT_EN
    checkOutput("rstIssued", 32'(issued), 32'h0);
`endif
    resetn = 1'b1;
    @(negedge clock);

    $display("[TB] sequence");
    for (int k = 0; k < 4; k++) pendQ.push_back(seqWords[k]);
    for (int k = 0; k < 4; k++) begin
      waitRun(20);
      checkOutput("seqIin", 32'(iin), 32'(seqWords[k]));
      checkOutput("seqBusy", 32'(busy), 32'h1);
      stepCycle(1'b0);
      stepCycle(1'b0);
      stepCycle(1'b1);
      checkOutput("seqBusyLow", 32'(busy), 32'h0);
    end
`ifdef INSTR_FEEDER_COUNT_EN
    checkOutput("seqIssued", 32'(issued), 32'd4);
`endif

    $display("[TB] full");
    baseRuns = runCount;
    acceptedCount = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
      if (lastAccepted) acceptedCount++;
    end
    checkOutput("fullAccepted", 32'(acceptedCount), 32'(DEPTH + 1));
    checkOutput("fullLevel", 32'(level), 32'(DEPTH));
    checkOutput("fullInReady", 32'(in_ready), 32'h0);
    checkOutput("fullFirstIssue", 32'(runCount - baseRuns), 32'd1);
    applyStimulus(1'b1, 16'h20F0, 1'b0, 1'b1);
    acceptedCount = int'(lastAccepted);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, 16'(16'h2100 + j), 1'b0, 1'b0);
      if (lastAccepted) acceptedCount++;
    end
    checkOutput("fullOneMore", 32'(acceptedCount), 32'd1);
    checkOutput("fullSecondIssue", 32'(iin), 32'h2001);
    checkOutput("fullRefill", 32'(level), 32'(DEPTH));
    drain();

    $display("[TB] push/pop overlap");
    baseRuns = runCount;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("ppLevelBefore", 32'(level), 32'd3);
    applyStimulus(1'b1, 16'h1004, 1'b0, 1'b0);
    checkOutput("ppLevel", 32'(level), 32'd3);
    checkOutput("ppRun", 32'(run), 32'h1);
    checkOutput("ppIin", 32'(iin), 32'h1001);
    for (int i = 5; i < 3 * DEPTH; i++) pendQ.push_back(16'(16'h1000 + i));
    for (int c = 0; c < 400 && pendQ.size() > 0; c++) stepCycle(c % 3 == 2);
    drain();
    checkOutput("ppWrapCount", 32'(runCount - baseRuns), 32'(3 * DEPTH));

    $display("[TB] flush");
    baseRuns = runCount;
    for (int i = 0; i < 6; i++) pendQ.push_back(16'(16'h3000 + i));
    repeat (6) stepCycle(1'b0);
    checkOutput("flPreLevel", 32'(level), 32'd5);
    applyStimulus(1'b1, 16'hDEAD, 1'b1, 1'b0);
    checkOutput("flLevel", 32'(level), 32'd0);
    checkOutput("flBusy", 32'(busy), 32'h0);
    checkOutput("flIin", 32'(iin), 32'h3000);
    checkOutput("flInReady", 32'(in_ready), 32'h1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("flDoneIgnored", 32'(runCount - baseRuns), 32'd1);
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("flNextRun", 32'(run), 32'h1);
    checkOutput("flNextIin", 32'(iin), 32'h5555);

    $display("[TB] reset mid-wait");
    applyStimulus(1'b1, 16'h6000, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h6001, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("arIin", 32'(iin), 32'h0);
    checkOutput("arRun", 32'(run), 32'h0);
    checkOutput("arBusy", 32'(busy), 32'h0);
    checkOutput("arLevel", 32'(level), 32'h0);
    checkOutput("arInReady", 32'(in_ready), 32'h1);
`ifdef INSTR_FEEDER_COUNT_EN
    checkOutput("arIssued", 32'(issued), 32'h0);
`endif
    @(negedge clock);
    resetn = 1'b1;
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("arNewRun", 32'(run), 32'h1);
    checkOutput("arNewIin", 32'(iin), 32'h7777);
`ifdef INSTR_FEEDER_COUNT_EN
    checkOutput("arNewIssued", 32'(issued), 32'h1);
`endif
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Instruction feeder sitting directly upstream of `processor`, driving its 16-bit `iin` input. Buffers instruction words pushed by a host or loader in a small FIFO and issues them one at a time. Each issue is marked by a one-cycle `run` strobe. The next word is not issued until the processor reports completion on `done`.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `AW`, $clog2(DEPTH): pointer width (derived, not overridden).

- `clock`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host presents `in_data`.
- `in_data`  in  16  instruction word.
- `in_ready`  out  1  FIFO can accept a word; equals !full.
- `flush`  in  1  synchronous: discard FIFO contents and abandon a pending wait.
- `done`  in  1  processor finished the current instruction.
- `iin`  out  16  instruction to processor (registered).
- `run`  out  1  one-cycle pulse: `iin` holds a newly issued word.
- `busy`  out  1  an instruction is issued and `done` has not yet been seen.
- `level`  out  AW+1  FIFO occupancy, 0..DEPTH.
- `issued`  out  16  issue counter (only with `INSTR_FEEDER_COUNT_EN`).

## Operation
- Reset values: `iin`=0, `run`=0, `busy`=0, `level`=0, `in_ready`=1, `issued`=0, state IDLE, both pointers 0.
- Push:
  - Occurs when `in_valid && in_ready` at an edge.
  - Word written at the write pointer; pointer wraps modulo DEPTH.
  - `in_ready` is purely !full; no pass-through. A push is refused while full, even if a pop occurs in the same cycle.
- State IDLE, FIFO non-empty:
  - At the edge, `iin` <= head, `run` <= 1, `busy` <= 1, pop (read pointer advances), go to WAIT.
- State WAIT:
  - `run` <= 0 after its one cycle.
  - `done` is sampled every WAIT cycle, including the cycle in which `run` is high.
  - `done`=1: `busy` <= 0, go to IDLE.
  - `done` is ignored in IDLE.
- Simultaneous push and pop: `level` is unchanged, both pointers advance.
- `flush`:
  - Pointers reset, `level` <= 0, state IDLE, `busy` <= 0, `run` <= 0.
  - Takes priority over a same-cycle push (push dropped) and over issue.
  - `iin` keeps its last value.
- `iin` holds the last issued word until the next issue.
- Asynchronous reset mid-WAIT returns every output to its reset value immediately. FIFO contents are lost.

## Timing
- Push accepted at edge N into an empty FIFO in IDLE: `run`=1 and the new `iin` are visible after edge N+1.
- Issue to issue: `done` seen at edge M gives IDLE after M. The next `run` rises after edge M+1, so the minimum gap is 2 cycles.
- `level` and `in_ready` update on the edge of the push or pop.
- `in_ready` drops in the cycle after the DEPTH-th unpopped push is accepted.

## Configuration
- `INSTR_FEEDER_COUNT_EN` defined:
  - `issued` port present; increments by 1 on every issue, wrapping 0xFFFF→0.
  - Cleared by reset only, not by `flush`.
- Not defined: `issued` port and counter logic absent; all other behaviour identical.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles → `iin`=0, `run`=0, `busy`=0, `level`=0, `in_ready`=1.
- Sequence:
  - Stimulus: push 0xA40A, 0xA805, 0x0120, 0x8000; return `done` 3 cycles after each `run`.
  - Required: four `run` pulses in order, with `iin` = 0xA40A, 0xA805, 0x0120, 0x8000; `busy` low between them; `issued`=4 when counting is enabled.
- Full:
  - Stimulus: with `done` held 0, push DEPTH+2 words.
  - Required: first word issued; `level` reaches DEPTH; `in_ready`=0; further pushes refused.
  - After one `done`: second word issued, and exactly one more push accepted.
- Simultaneous push/pop:
  - Stimulus: at `level`=3, push in the same cycle an issue occurs.
  - Required: `level` stays 3; pointers wrap correctly across 3×DEPTH words with no loss or reordering.
- Flush:
  - Stimulus: in WAIT with `level`=5, assert `flush` with `in_valid`=1.
  - Required: `level`=0, `busy`=0, push dropped, `iin` unchanged.
  - A later `done` is ignored.
- Reset mid-operation:
  - Stimulus: drop `resetn` during WAIT.
  - Required: outputs reach reset values asynchronously.
  - After release, a new push issues normally 1 cycle later.
